// File: rtl/branch_predictor_param.sv
// IF-stage branch/jump predictor: saturating-counter PHT, tagged BTB, return address stack,
// and an IF->ID record of the prediction made, checked against the resolution in ID.
module branch_predictor_param #(
  parameter int INDEX_BITS = 3,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 8,
  parameter int RAS_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] pc_if,
  input  logic [31:0] inst_if,
  input  logic [31:0] pc_id,
  input  logic [31:0] inst_id,
  input  logic        branch_decision,
  input  logic [31:0] branch_target_id,
  output logic        branch_prediction,
  output logic        branch_redo,
  output logic [31:0] branch_target_if
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic br;
    logic jal;
    logic ret;
    logic ijmp;
    logic call;
  } cls_t;

  function automatic cls_t decode(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    cls_t c;
    logic rd_link;
    logic rs1_link;
    rd_link  = (rd == 5'd1) || (rd == 5'd5);
    rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    c.br   = (op == OP_BRANCH);
    c.jal  = (op == OP_JAL);
    c.ret  = (op == OP_JALR) && (rd == 5'd0) && rs1_link;
    c.ijmp = (op == OP_JALR) && !c.ret;
    c.call = ((op == OP_JAL) || (op == OP_JALR)) && rd_link;
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - 1'b1;
  endfunction

  logic [CTR_BITS-1:0] pht_q [ENTRIES];
  logic [CTR_BITS-1:0] pht_d [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag_d [ENTRIES];
  logic [31:0]         btb_tgt_q [ENTRIES];
  logic [31:0]         btb_tgt_d [ENTRIES];
  logic [31:0]         ras_q [RAS_DEPTH];
  logic [31:0]         ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
  logic                pred_taken_id_q, pred_taken_id_d;
  logic [31:0]         pred_target_id_q, pred_target_id_d;

  cls_t                cls_if, cls_id;
  logic [INDEX_BITS-1:0] idx_if, idx_id;
  logic [TAG_BITS-1:0] tag_if, tag_id;
  logic [31:0]         pc_if_next, pc_id_next;
  logic                hit_if, taken_if, actual_taken, redo;
  logic                ras_nonempty;
  logic [31:0]         ras_top, tgt_if, pred_target_if;
  logic                unused_inst;

  assign unused_inst = ^{inst_if[31:20], inst_if[14:12], inst_id[31:20], inst_id[14:12]};

  assign cls_if     = decode(inst_if[6:0], inst_if[11:7], inst_if[19:15]);
  assign cls_id     = decode(inst_id[6:0], inst_id[11:7], inst_id[19:15]);
  assign idx_if     = pc_if[INDEX_BITS+1:2];
  assign idx_id     = pc_id[INDEX_BITS+1:2];
  assign tag_if     = pc_if[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign tag_id     = pc_id[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign pc_if_next = pc_if + 32'd4;
  assign pc_id_next = pc_id + 32'd4;

  always_comb begin
    actual_taken = cls_id.br ? branch_decision : 1'b1;
    redo = (cls_id.br || cls_id.jal || cls_id.ret || cls_id.ijmp) &&
           ((actual_taken != pred_taken_id_q) ||
            (actual_taken && (branch_target_id != pred_target_id_q)));

    // IF sees the stack as it will be after this cycle's ID push/pop
    if (cls_id.call) begin
      ras_nonempty = 1'b1;
      ras_top      = pc_id_next;
    end else if (cls_id.ret) begin
      ras_nonempty = (ras_cnt_q > CNT_W'(1));
      ras_top      = ras_q[ptr_dec(ptr_dec(ras_ptr_q))];
    end else begin
      ras_nonempty = (ras_cnt_q != '0);
      ras_top      = ras_q[ptr_dec(ras_ptr_q)];
    end

    hit_if   = btb_valid_q[idx_if] && (btb_tag_q[idx_if] == tag_if);
    taken_if = 1'b0;
    tgt_if   = btb_tgt_q[idx_if];
    if (cls_if.br) begin
      taken_if = pht_q[idx_if][CTR_BITS-1] && hit_if;
    end else if (cls_if.jal || cls_if.ijmp) begin
      taken_if = hit_if;
    end else if (cls_if.ret) begin
      taken_if = ras_nonempty;
      tgt_if   = ras_top;
    end
    pred_target_if = taken_if ? tgt_if : pc_if_next;

    branch_redo       = redo;
    branch_prediction = !redo && taken_if;
    branch_target_if  = redo ? (actual_taken ? branch_target_id : pc_id_next) : pred_target_if;
  end

  always_comb begin
    pht_d            = pht_q;
    btb_valid_d      = btb_valid_q;
    btb_tag_d        = btb_tag_q;
    btb_tgt_d        = btb_tgt_q;
    ras_d            = ras_q;
    ras_ptr_d        = ras_ptr_q;
    ras_cnt_d        = ras_cnt_q;
    pred_taken_id_d  = pred_taken_id_q;
    pred_target_id_d = pred_target_id_q;
    if (!stall) begin
      pred_taken_id_d  = redo ? 1'b0 : taken_if;
      pred_target_id_d = redo ? 32'd0 : pred_target_if;
      if (cls_id.br) begin
        if (branch_decision && (pht_q[idx_id] != CTR_MAX)) begin
          pht_d[idx_id] = pht_q[idx_id] + 1'b1;
        end else if (!branch_decision && (pht_q[idx_id] != '0)) begin
          pht_d[idx_id] = pht_q[idx_id] - 1'b1;
        end
      end
      if ((cls_id.br && branch_decision) || cls_id.jal || cls_id.ijmp) begin
        btb_valid_d[idx_id] = 1'b1;
        btb_tag_d[idx_id]   = tag_id;
        btb_tgt_d[idx_id]   = branch_target_id;
      end
      // a return that also links swaps the top entry in place
      if (cls_id.ret && cls_id.call && (ras_cnt_q != '0)) begin
        ras_d[ptr_dec(ras_ptr_q)] = pc_id_next;
      end else if (cls_id.call) begin
        ras_d[ras_ptr_q] = pc_id_next;
        ras_ptr_d        = ptr_inc(ras_ptr_q);
        ras_cnt_d        = (ras_cnt_q == CNT_FULL) ? CNT_FULL : ras_cnt_q + 1'b1;
      end else if (cls_id.ret && (ras_cnt_q != '0)) begin
        ras_ptr_d = ptr_dec(ras_ptr_q);
        ras_cnt_d = ras_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i]     <= CTR_INIT;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
      btb_valid_q      <= '0;
      ras_ptr_q        <= '0;
      ras_cnt_q        <= '0;
      pred_taken_id_q  <= 1'b0;
      pred_target_id_q <= '0;
    end else begin
      pht_q            <= pht_d;
      btb_valid_q      <= btb_valid_d;
      btb_tag_q        <= btb_tag_d;
      btb_tgt_q        <= btb_tgt_d;
      ras_q            <= ras_d;
      ras_ptr_q        <= ras_ptr_d;
      ras_cnt_q        <= ras_cnt_d;
      pred_taken_id_q  <= pred_taken_id_d;
      pred_target_id_q <= pred_target_id_d;
    end
  end
endmodule
